// File: rtl/ifetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
// Imported by the sequencer top and its next-PC helper.
package ifetch_pkg;

  localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;
  // addi x0,x0,0
  localparam logic [31:0] IFETCH_NOP      = 32'h0000_0013;
  localparam int unsigned PC_STEP         = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StValid = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_pc_next.sv
// Next-PC selection: sequential pc+4 or word-aligned branch/jump target,
// plus detection of a taken target with nonzero low bits.
module ifetch_pc_next
  import ifetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pc_sel,
  input  logic [XLEN-1:0] i_alu_target,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_pc_tgt;

  // Sequential increment wraps modulo 2^XLEN by construction
  assign w_pc_seq     = i_pc + XLEN'(PC_STEP);
  assign w_pc_tgt     = {i_alu_target[XLEN-1:2], 2'b00};
  assign o_next_pc    = i_pc_sel ? w_pc_tgt : w_pc_seq;
  assign o_misaligned = i_pc_sel & (|i_alu_target[1:0]);

endmodule

// File: rtl/ifetch_sequencer.sv
// Instruction-fetch front end: owns the PC, runs a req/ack fetch to instruction
// memory and holds each fetched instruction until downstream retires it.
module ifetch_sequencer
  import ifetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(IFETCH_RESET_PC),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(IFETCH_NOP)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc_out,
  input  logic            stall,
  input  logic            PCSel,
  input  logic [XLEN-1:0] alu_target,
  output logic            misalign_err
);

  ifetch_state_e   r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_instr_valid;
  logic            r_misalign_err;

  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;

  ifetch_pc_next #(
    .XLEN (XLEN)
  ) u_pc_next (
    .i_pc         (r_pc),
    .i_pc_sel     (PCSel),
    .i_alu_target (alu_target),
    .o_next_pc    (w_next_pc),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_pc           <= RESET_PC;
      r_instr        <= NOP_INSTR;
      r_instr_valid  <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= 1'b0;
      case (r_state)
        StIdle: begin
          r_state <= StFetch;
        end
        StFetch: begin
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= StValid;
          end
        end
        StValid: begin
          // PCSel/alu_target only matter on the retire edge
          if (!stall) begin
            r_pc           <= w_next_pc;
            r_instr        <= NOP_INSTR;
            r_instr_valid  <= 1'b0;
            r_misalign_err <= w_misaligned;
            r_state        <= StFetch;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Request is a pure state decode so it falls in the same cycle VALID is entered
  assign imem_req     = (r_state == StFetch);
  assign imem_addr    = r_pc;
  assign pc_out       = r_pc;
  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Directed bench for ifetch_sequencer: inputs change and outputs are sampled
// at the falling edge, expectations are hand-computed constants.
module tb_ifetch_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic        stall;
  logic        PCSel;
  logic [31:0] alu_target;
  logic        misalign_err;

  int n_checks = 0;
  int n_errs   = 0;

  ifetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc_out       (pc_out),
    .stall        (stall),
    .PCSel        (PCSel),
    .alu_target   (alu_target),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    PCSel      = 1'b0;
    alu_target = 32'h0;
    @(negedge clk);
    tick();
    tick();

    check("rst_req",   {31'b0, imem_req},     32'h0);
    check("rst_addr",  imem_addr,             32'h0);
    check("rst_instr", instr,                 32'h13);
    check("rst_valid", {31'b0, instr_valid},  32'h0);
    check("rst_pc",    pc_out,                32'h0);
    check("rst_mis",   {31'b0, misalign_err}, 32'h0);

    // 0-wait fetch at address 0
    rst = 1'b0;
    tick();
    check("f0_req",  {31'b0, imem_req}, 32'h1);
    check("f0_addr", imem_addr,         32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h00400793;
    tick();
    imem_ack = 1'b0;
    check("v0_instr", instr,                32'h00400793);
    check("v0_valid", {31'b0, instr_valid}, 32'h1);
    check("v0_pc",    pc_out,               32'h0);
    check("v0_req",   {31'b0, imem_req},    32'h0);
    tick();
    check("f4_req",   {31'b0, imem_req},    32'h1);
    check("f4_addr",  imem_addr,            32'h4);
    check("f4_valid", {31'b0, instr_valid}, 32'h0);
    check("f4_instr", instr,                32'h13);

    // Fetch at 4, retire to 8
    imem_ack   = 1'b1;
    imem_rdata = 32'h00000013;
    tick();
    imem_ack = 1'b0;
    tick();

    // 3 wait cycles at address 8
    for (int i = 0; i < 4; i++) begin
      check("w_req",  {31'b0, imem_req},    32'h1);
      check("w_addr", imem_addr,            32'h8);
      check("w_val",  {31'b0, instr_valid}, 32'h0);
      if (i < 3) tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hfef42623;
    tick();
    imem_ack = 1'b0;
    check("w_vinstr", instr,                32'hfef42623);
    check("w_vvalid", {31'b0, instr_valid}, 32'h1);
    check("w_vpc",    pc_out,               32'h8);

    // Hold under stall, wiggling PCSel/target and a stray ack
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      PCSel      = i[0];
      alu_target = 32'h100 + 32'(i) * 32'h3;
      imem_ack   = (i == 2);
      imem_rdata = 32'hdeadbeef;
      tick();
      check("s_instr", instr,                 32'hfef42623);
      check("s_pc",    pc_out,                32'h8);
      check("s_valid", {31'b0, instr_valid},  32'h1);
      check("s_req",   {31'b0, imem_req},     32'h0);
      check("s_mis",   {31'b0, misalign_err}, 32'h0);
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    PCSel    = 1'b0;
    tick();
    check("s_next", imem_addr, 32'hC);

    // Fetch at C, retire sequentially to 0x10, fetch beq
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    check("b_addr", imem_addr, 32'h10);
    imem_ack   = 1'b1;
    imem_rdata = 32'h00058663;
    tick();
    imem_ack = 1'b0;
    check("b_instr", instr,  32'h00058663);
    check("b_pc",    pc_out, 32'h10);
    PCSel      = 1'b1;
    alu_target = 32'h1C;
    tick();
    PCSel = 1'b0;
    check("b_tgt", imem_addr,             32'h1C);
    check("b_mis", {31'b0, misalign_err}, 32'h0);

    // Misaligned taken target
    imem_ack = 1'b1;
    tick();
    imem_ack   = 1'b0;
    PCSel      = 1'b1;
    alu_target = 32'h22;
    tick();
    PCSel = 1'b0;
    check("m_addr", imem_addr,             32'h20);
    check("m_mis",  {31'b0, misalign_err}, 32'h1);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("m_mis_end", {31'b0, misalign_err}, 32'h0);

    // Jump to top word, then wrap
    PCSel      = 1'b1;
    alu_target = 32'hFFFF_FFFC;
    tick();
    PCSel = 1'b0;
    check("x_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("x_pc", pc_out, 32'hFFFF_FFFC);
    tick();
    check("x_wrap", imem_addr,             32'h0);
    check("x_mis",  {31'b0, misalign_err}, 32'h0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    check("x_addr4", imem_addr, 32'h4);

    // Reset mid-fetch, then a late ack in IDLE
    rst = 1'b1;
    tick();
    check("r_req", {31'b0, imem_req}, 32'h0);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hABCD_0000;
    tick();
    imem_ack = 1'b0;
    check("r_instr", instr,                32'h13);
    check("r_valid", {31'b0, instr_valid}, 32'h0);
    check("r_pc",    pc_out,               32'h0);
    check("r_req2",  {31'b0, imem_req},    32'h1);

    // Reset and ack together: reset wins
    rst      = 1'b1;
    imem_ack = 1'b1;
    tick();
    rst      = 1'b0;
    imem_ack = 1'b0;
    check("ra_instr", instr,                32'h13);
    check("ra_valid", {31'b0, instr_valid}, 32'h0);

    // Reset in VALID discards the instruction
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_2222;
    tick();
    imem_ack = 1'b0;
    stall    = 1'b1;
    check("rv_valid1", {31'b0, instr_valid}, 32'h1);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    check("rv_valid0", {31'b0, instr_valid}, 32'h0);
    check("rv_instr",  instr,                32'h13);
    tick();
    check("rv_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
